// File: rtl/reset_release_sequencer.sv
`timescale 1ns/1ps
// reset_release_sequencer
//   Reset synchroniser and sequencer for the root of a clock domain.
//
//   - A SYNC_STAGES-deep flop chain synchronises the deassertion of the
//     asynchronous reset to clk.
//   - NUM_OUT downstream resets are then released one at a time, GAP cycles
//     apart, in ascending order.
//   - Once every reset is released, ready goes high and the data path opens.
//
//   Optional feature, enabled by defining RSTSEQ_SOFT_RST_EN:
//     soft_req, sampled while running, re-asserts all downstream resets for
//     HOLD cycles, pulses soft_ack and then replays the release sequence.
//     When the macro is undefined, soft_req is ignored and soft_ack is tied
//     low; the port list is the same in both builds.
//
// Ports
//   clk       in   1        clock
//   reset     in   1        async active-high reset (deassertion synchronised)
//   soft_req  in   1        soft-reset request, level-sampled while running
//   soft_ack  out  1        one-cycle pulse when the soft-reset hold completes
//   rst_out   out  NUM_OUT  sequenced active-high resets, bit 0 released first
//   ready     out  1        high once all rst_out bits are released
//   data_in   in   DATA_W   input data
//   data_out  out  DATA_W   registered data, forced to zero while ready is low
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int GAP         = 4,
  parameter int HOLD        = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_req,
  output logic              soft_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic              ready,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int CNT_MAX = (GAP > HOLD) ? GAP : HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_OUT) + 1;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN,
    ST_SOFT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_rst;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_OUT-1:0]     rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic                   soft_ack_q, soft_ack_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;

  // Synchroniser: the chain is preset to all ones by reset and shifts in
  // zeros, so sync_rst falls on the SYNC_STAGES-th edge after reset falls.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign sync_rst = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    soft_ack_d = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        cnt_d     = '0;
        idx_d     = '0;
        if (!sync_rst) begin
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          for (int i = 0; i < NUM_OUT; i++) begin
            if (idx_q == IDX_W'(i)) begin
              rst_out_d[i] = 1'b0;
            end
          end
          if (idx_q == IDX_W'(NUM_OUT - 1)) begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        // The first RUN edge only raises ready, so a request is honoured
        // only after ready has been visible for at least one cycle.
        if (!ready_q) begin
          ready_d = 1'b1;
        end
`ifdef RSTSEQ_SOFT_RST_EN
        else if (soft_req) begin
          state_d   = ST_SOFT;
          rst_out_d = '1;
          ready_d   = 1'b0;
          cnt_d     = '0;
        end
`endif
      end

      ST_SOFT: begin
`ifdef RSTSEQ_SOFT_RST_EN
        if (cnt_q == CNT_W'(HOLD - 1)) begin
          soft_ack_d = 1'b1;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        // Unreachable without the soft-reset feature; recover via ASSERT.
        state_d = ST_ASSERT;
`endif
      end

      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  always_comb begin
    data_out_d = ready_q ? data_in : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '1;
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      soft_ack_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      soft_ack_q <= soft_ack_d;
      data_out_q <= data_out_d;
    end
  end

`ifndef RSTSEQ_SOFT_RST_EN
  logic unused_soft_req;
  assign unused_soft_req = soft_req;
`endif

  assign rst_out  = rst_out_q;
  assign ready    = ready_q;
  assign soft_ack = soft_ack_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
`timescale 1ns/1ps
// Directed bench for reset_release_sequencer (default parameters).
// Expected outputs come from a closed-form timeline: the number of edges
// since the release phase began decides which rst_out bits are low and
// whether ready is high. Each step pushes its expectation before the edge
// and pops it for comparison after the edge.
module tb_reset_release_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_OUT     = 3;
  localparam int GAP         = 4;
  localparam int HOLD        = 8;
  localparam int DATA_W      = 8;
  localparam int RDY_REL     = GAP * NUM_OUT + 1;

  logic              clk;
  logic              reset;
  logic              soft_req;
  logic              soft_ack;
  logic [NUM_OUT-1:0] rst_out;
  logic              ready;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  reset_release_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .NUM_OUT    (NUM_OUT),
    .GAP        (GAP),
    .HOLD       (HOLD),
    .DATA_W     (DATA_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .soft_req(soft_req),
    .soft_ack(soft_ack),
    .rst_out (rst_out),
    .ready   (ready),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_OUT-1:0] rst;
    logic               rdy;
    logic               ack;
    logic [DATA_W-1:0]  dat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rel;           // edges since release phase entry, after the coming edge
  logic prev_rdy;      // expected ready before the coming edge
  bit   soft_pending;  // a soft reset is in its hold phase

  function automatic logic [NUM_OUT-1:0] rst_exp(input int r);
    logic [NUM_OUT-1:0] v;
    for (int i = 0; i < NUM_OUT; i++) begin
      v[i] = (r < GAP * (i + 1));
    end
    return v;
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_now(input string tag);
    check1({tag, "_rst_out"},  32'(rst_out),  32'({NUM_OUT{1'b1}}));
    check1({tag, "_ready"},    32'(ready),    32'd0);
    check1({tag, "_soft_ack"}, 32'(soft_ack), 32'd0);
    check1({tag, "_data_out"}, 32'(data_out), 32'd0);
  endtask

  // Begin the timeline after reset deassertion: the synchroniser takes
  // SYNC_STAGES edges and the ASSERT->RELEASE transition one more.
  task automatic start_release();
    rel      = -SYNC_STAGES - 1;
    prev_rdy = 1'b0;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    exp_t got;
    rel++;
    e.rst = rst_exp(rel);
    e.rdy = (rel >= RDY_REL);
    e.ack = soft_pending && (rel == 0);
    if (rel == 0) soft_pending = 1'b0;
    e.dat = prev_rdy ? data_in : '0;
    prev_rdy = e.rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check1({tag, "_rst_out"},  32'(rst_out),  32'(got.rst));
    check1({tag, "_ready"},    32'(ready),    32'(got.rdy));
    check1({tag, "_soft_ack"}, 32'(soft_ack), 32'(got.ack));
    check1({tag, "_data_out"}, 32'(data_out), 32'(got.dat));
  endtask

  initial begin
    reset        = 1'b1;
    soft_req     = 1'b0;
    data_in      = 8'hA5;
    soft_pending = 1'b0;
    start_release();

    // Power-on reset.
    #1;
    chk_reset_now("por_async");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_now("por_hold");
    reset = 1'b0;
    start_release();
    repeat (20) tick("por");

    // Data follows data_in with one cycle latency while ready.
    data_in = 8'h3C;
    tick("data");
    data_in = 8'hA5;
    tick("data");

    // Reset asserted while rst_out == 110.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_release();
    repeat (7) tick("pre_mid");
    #2;
    reset = 1'b1;
    #1;
    chk_reset_now("mid_seq");
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_release();

    // Replay, with soft_req asserted during RELEASE (must be ignored).
    repeat (6) tick("replay");
    soft_req = 1'b1;
    repeat (4) tick("soft_in_release");
    soft_req = 1'b0;
    repeat (8) tick("replay");

`ifdef RSTSEQ_SOFT_RST_EN
    // One-cycle soft request in RUN: HOLD cycles asserted, ack, replay.
    soft_req     = 1'b1;
    soft_pending = 1'b1;
    rel          = -HOLD - 1;
    tick("soft_enter");
    soft_req = 1'b0;
    repeat (HOLD) tick("soft_hold");
    repeat (RDY_REL + 1) tick("soft_replay");
`else
    // Without the feature, soft_req in RUN has no effect.
    soft_req = 1'b1;
    repeat (5) tick("soft_ignored");
    soft_req = 1'b0;
    tick("soft_ignored");
`endif

    // Sub-cycle reset glitch while ready is high.
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk_reset_now("glitch");
    start_release();
    repeat (RDY_REL + SYNC_STAGES + 3) tick("glitch_replay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
